// File: rtl/led_blinker_pkg.sv
// led_blinker shared types: channel mode
// encoding and its field width.
package led_blinker_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PULSE = 2'd3
   } mode_e;

endpackage

// File: rtl/led_blinker_chan.sv
// One LED channel: mode/half-period/count
// registers plus toggle and pulse-count logic.
// Ports: clk, rst_n, tick (1 ms strobe),
//   we/mode/half_ms/count (channel load),
//   q (active-high level), done (PULSE end).
module led_blinker_chan
   import led_blinker_pkg::*;
#(
   parameter int hp_w  = 16,
   parameter int cnt_w = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             we,
   input  mode_e            mode,
   input  logic [hp_w-1:0]  half_ms,
   input  logic [cnt_w-1:0] count,
   output logic             q,
   output logic             done
);

   mode_e            mode_r, mode_n;
   logic [hp_w-1:0]  half_r, half_n;
   logic [hp_w-1:0]  ms_r, ms_n;
   logic [cnt_w-1:0] rem_r, rem_n;
   logic             q_r, q_n;
   logic             done_r, done_n;
   logic             run;
   logic             wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r <= MODE_OFF;
         half_r <= hp_w'(1);
         ms_r   <= '0;
         rem_r  <= '0;
         q_r    <= 1'b0;
         done_r <= 1'b0;
      end else begin
         mode_r <= mode_n;
         half_r <= half_n;
         ms_r   <= ms_n;
         rem_r  <= rem_n;
         q_r    <= q_n;
         done_r <= done_n;
      end
   end

   always_comb begin
      mode_n = mode_r;
      half_n = half_r;
      ms_n   = ms_r;
      rem_n  = rem_r;
      q_n    = q_r;
      done_n = done_r;
      // A finished pulse train freezes.
      run  = (mode_r == MODE_BLINK) ||
             (mode_r == MODE_PULSE && !done_r);
      wrap = (ms_r == half_r - hp_w'(1));
      if (we) begin
         mode_n = mode;
         half_n = (half_ms == '0) ? hp_w'(1)
                                  : half_ms;
         rem_n  = count;
         ms_n   = '0;
         done_n = 1'b0;
         unique case (mode)
            MODE_OFF:   q_n = 1'b0;
            MODE_ON:    q_n = 1'b1;
            MODE_BLINK: q_n = 1'b1;
            MODE_PULSE: begin
               q_n    = (count != '0);
               done_n = (count == '0);
            end
            default:    q_n = 1'b0;
         endcase
      end else if (tick && run) begin
         if (wrap) begin
            ms_n = '0;
            q_n  = ~q_r;
            // Falling edge ends one on-phase.
            if (q_r && mode_r == MODE_PULSE) begin
               rem_n = rem_r - cnt_w'(1);
               if (rem_r == cnt_w'(1))
                  done_n = 1'b1;
            end
         end else begin
            ms_n = ms_r + hp_w'(1);
         end
      end
   end

   assign q    = q_r;
   assign done = done_r;

endmodule

// File: rtl/led_blinker.sv
// Multi-channel LED pattern generator: shared
// 1 ms prescaler, write decode, N channels.
// Ports: clk, rst_n, cfg_we/cfg_ch/cfg_mode/
//   cfg_half_ms/cfg_count (channel write),
//   q (LEDs), done (pulse end), tick (1 ms).
// LED_BLINKER_ACTIVE_LOW_EN: drive q inverted.
module led_blinker
   import led_blinker_pkg::*;
#(
   parameter int clk_freq_hz = 50_000_000,
   parameter int channels    = 4,
   parameter int hp_w        = 16,
   parameter int cnt_w       = 8,
   parameter int ch_w        =
      (channels > 1) ? $clog2(channels) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [ch_w-1:0]     cfg_ch,
   input  logic [MODE_W-1:0]   cfg_mode,
   input  logic [hp_w-1:0]     cfg_half_ms,
   input  logic [cnt_w-1:0]    cfg_count,
   output logic [channels-1:0] q,
   output logic [channels-1:0] done,
   output logic                tick
);

   localparam int DIV = clk_freq_hz / 1000;
   localparam int PW  =
      (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0]       pre;
   logic [channels-1:0] q_int;

   assign tick = (pre == PW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pre <= '0;
      else if (tick)
         pre <= '0;
      else
         pre <= pre + PW'(1);
   end

   // Out-of-range indices match no channel,
   // so such writes fall away here.
   for (genvar g = 0; g < channels; g++) begin
      : g_ch
      led_blinker_chan #(
         .hp_w  (hp_w),
         .cnt_w (cnt_w)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .tick    (tick),
         .we      (cfg_we &&
                   (cfg_ch == ch_w'(g))),
         .mode    (mode_e'(cfg_mode)),
         .half_ms (cfg_half_ms),
         .count   (cfg_count),
         .q       (q_int[g]),
         .done    (done[g])
      );
   end

`ifdef LED_BLINKER_ACTIVE_LOW_EN
   assign q = ~q_int;
`else
   assign q = q_int;
`endif

endmodule
